// File: rtl/rgmii_ddr_rx_if.sv
// Payload stream from the RGMII receive front end to the MAC receive logic.
// The front end drives the master side. There is no backpressure: m_valid is a
// one-cycle strobe. m_last, m_error and frame_len/frame_len_valid mark the
// frame end.
interface rgmii_ddr_rx_if #(
   parameter int CNT_WIDTH = 16
);
   logic [7:0]           m_data;
   logic                 m_valid;
   logic                 m_last;
   logic                 m_error;
   logic [CNT_WIDTH-1:0] frame_len;
   logic                 frame_len_valid;

   modport master (
      output m_data, m_valid, m_last, m_error, frame_len, frame_len_valid
   );

   modport slave (
      input m_data, m_valid, m_last, m_error, frame_len, frame_len_valid
   );
endinterface

// File: rtl/rgmii_ddr_rx.sv
// RGMII receive front end. It captures the 4-bit DDR data and the DDR control
// line on both edges of the phase-aligned RX clock and rebuilds GMII bytes.
// It strips the preamble and SFD, then delivers the payload through a one-byte
// hold register so that the final byte can carry m_last.
// Pin to m_valid latency is 3 rising edges.
// Optional feature macro: RGMII_RX_INBAND_STATUS_EN registers the in-band link,
// speed and duplex status from inter-frame idle bytes.
module rgmii_ddr_rx #(
   parameter int MIN_PREAMBLE = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            rgmii_rxd,
   input  logic                  rgmii_rx_ctl,
   rgmii_ddr_rx_if.master        m,
   output logic                  stat_bad_frame,
   output logic                  link_up,
   output logic [1:0]            speed,
   output logic                  full_duplex
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREAMBLE,
      S_DATA,
      S_DROP
   } state_t;

   localparam logic [2:0] MIN_PRE = 3'(MIN_PREAMBLE);
   localparam logic [7:0] PRE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;

   // Pin capture registers
   logic [3:0] r_rise_d;
   logic       r_rise_c;
   logic [3:0] r_fall_d;
   logic       r_fall_c;

   // Assembled single-rate GMII byte
   logic [7:0] r_byte;
   logic       r_dv;
   logic       r_er;

   // Frame state
   state_t               r_state;
   logic [2:0]           r_pre_cnt;
   logic [7:0]           r_hold;
   logic                 r_hold_vld;
   logic [CNT_WIDTH-1:0] r_len_cnt;
   logic                 r_err_flag;

   // Registered outputs
   logic [7:0]           r_m_data;
   logic                 r_m_valid;
   logic                 r_m_last;
   logic                 r_m_error;
   logic [CNT_WIDTH-1:0] r_frame_len;
   logic                 r_frame_len_valid;
   logic                 r_bad;

   // Rising-edge half: low data nibble and rx_dv.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rise_d <= '0;
         r_rise_c <= 1'b0;
      end else begin
         // NOTE: all clocked state uses non-blocking assignments. Every register
         // then samples the pre-edge value of its sources, and the pipeline
         // stages do not collapse into each other.
         r_rise_d <= rgmii_rxd;
         r_rise_c <= rgmii_rx_ctl;
      end
   end

   // Falling-edge half: high data nibble and rx_dv ^ rx_er.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fall_d <= '0;
         r_fall_c <= 1'b0;
      end else begin
         r_fall_d <= rgmii_rxd;
         r_fall_c <= rgmii_rx_ctl;
      end
   end

   // Realign both halves into one byte on the next rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte <= '0;
         r_dv   <= 1'b0;
         r_er   <= 1'b0;
      end else begin
         r_byte <= {r_fall_d, r_rise_d};
         r_dv   <= r_rise_c;
         r_er   <= r_rise_c ^ r_fall_c;
      end
   end

   // Frame FSM: preamble/SFD detection, payload hold register, length and error tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state           <= S_IDLE;
         r_pre_cnt         <= '0;
         r_hold            <= '0;
         r_hold_vld        <= 1'b0;
         r_len_cnt         <= '0;
         r_err_flag        <= 1'b0;
         r_m_data          <= '0;
         r_m_valid         <= 1'b0;
         r_m_last          <= 1'b0;
         r_m_error         <= 1'b0;
         r_frame_len       <= '0;
         r_frame_len_valid <= 1'b0;
         r_bad             <= 1'b0;
      end else begin
         r_m_valid         <= 1'b0;
         r_m_last          <= 1'b0;
         r_m_error         <= 1'b0;
         r_frame_len_valid <= 1'b0;
         r_bad             <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (r_dv) begin
                  if (!r_er && r_byte == PRE_BYTE) begin
                     r_state   <= S_PREAMBLE;
                     r_pre_cnt <= 3'd1;
                  end else begin
                     r_state <= S_DROP;
                  end
               end
            end

            S_PREAMBLE: begin
               if (!r_dv) begin
                  r_state <= S_IDLE;
                  r_bad   <= 1'b1;
               end else if (r_er) begin
                  r_state <= S_DROP;
               end else if (r_byte == PRE_BYTE) begin
                  if (r_pre_cnt != 3'd7) begin
                     r_pre_cnt <= r_pre_cnt + 3'd1;
                  end
               end else if (r_byte == SFD_BYTE && r_pre_cnt >= MIN_PRE) begin
                  r_state    <= S_DATA;
                  r_len_cnt  <= '0;
                  r_err_flag <= 1'b0;
                  r_hold_vld <= 1'b0;
               end else begin
                  r_state <= S_DROP;
               end
            end

            S_DATA: begin
               if (r_dv) begin
                  // The new byte waits in the hold register. The previous byte
                  // goes out now, because only a later dv=0 can show which byte
                  // is last.
                  r_hold     <= r_byte;
                  r_hold_vld <= 1'b1;
                  if (r_er) begin
                     r_err_flag <= 1'b1;
                  end
                  if (r_len_cnt != '1) begin
                     r_len_cnt <= r_len_cnt + CNT_WIDTH'(1);
                  end
                  if (r_hold_vld) begin
                     r_m_data  <= r_hold;
                     r_m_valid <= 1'b1;
                  end
               end else begin
                  r_state    <= S_IDLE;
                  r_hold_vld <= 1'b0;
                  if (r_hold_vld) begin
                     r_m_data          <= r_hold;
                     r_m_valid         <= 1'b1;
                     r_m_last          <= 1'b1;
                     r_m_error         <= r_err_flag;
                     r_frame_len       <= r_len_cnt;
                     r_frame_len_valid <= 1'b1;
                  end else begin
                     // SFD followed directly by end of frame: nothing to deliver.
                     r_bad <= 1'b1;
                  end
               end
            end

            S_DROP: begin
               if (!r_dv) begin
                  r_state <= S_IDLE;
                  r_bad   <= 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m.m_data          = r_m_data;
   assign m.m_valid         = r_m_valid;
   assign m.m_last          = r_m_last;
   assign m.m_error         = r_m_error;
   assign m.frame_len       = r_frame_len;
   assign m.frame_len_valid = r_frame_len_valid;
   assign stat_bad_frame    = r_bad;

`ifdef RGMII_RX_INBAND_STATUS_EN
   logic       r_link_up;
   logic [1:0] r_speed;
   logic       r_full_duplex;

   // Clean idle bytes (dv=0, er=0) carry PHY status. The status holds while a frame is received.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_link_up     <= 1'b0;
         r_speed       <= 2'b00;
         r_full_duplex <= 1'b0;
      end else if (!r_dv && !r_er) begin
         r_link_up     <= r_byte[0];
         r_speed       <= r_byte[2:1];
         r_full_duplex <= r_byte[3];
      end
   end

   assign link_up     = r_link_up;
   assign speed       = r_speed;
   assign full_duplex = r_full_duplex;
`else
   assign link_up     = 1'b0;
   assign speed       = 2'b00;
   assign full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_ddr_rx.sv
// Testbench for rgmii_ddr_rx. A table of whole-frame vectors lists the pin
// bytes and the expected payload beats, flags, length and discard pulses.
// Hand-written sequences cover reset in mid-frame, back-to-back frames and the
// in-band status.
module tb_rgmii_ddr_rx;

   localparam int CW = 16;

   logic       clk;
   logic       rst_n;
   logic [3:0] rgmii_rxd;
   logic       rgmii_rx_ctl;
   logic       stat_bad_frame;
   logic       link_up;
   logic [1:0] speed;
   logic       full_duplex;

   rgmii_ddr_rx_if #(.CNT_WIDTH(CW)) m_if ();

   rgmii_ddr_rx #(
      .MIN_PREAMBLE (2),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rgmii_rxd      (rgmii_rxd),
      .rgmii_rx_ctl   (rgmii_rx_ctl),
      .m              (m_if),
      .stat_bad_frame (stat_bad_frame),
      .link_up        (link_up),
      .speed          (speed),
      .full_duplex    (full_duplex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   logic [7:0] idle_byte = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]    d;
      logic          last;
      logic          err;
      logic          flv;
      logic [CW-1:0] len;
      int            c;
   } beat_t;

   beat_t beats[$];
   int    pin_q[$];
   int    bad_cnt   = 0;
   int    stray_flv = 0;

   // Output monitor, sampled on the falling edge away from the active edge
   always @(negedge clk) begin
      if (m_if.m_valid) begin
         beats.push_back('{d: m_if.m_data, last: m_if.m_last, err: m_if.m_error,
                           flv: m_if.frame_len_valid, len: m_if.frame_len, c: cyc});
      end else if (m_if.frame_len_valid || m_if.m_last) begin
         stray_flv++;
      end
      if (stat_bad_frame) bad_cnt++;
   end

   typedef struct {
      int              n_pre;
      logic [7:0]      sfd;
      int              n_pay;
      logic [7:0][7:0] pay;
      int              err_idx;
      int              exp_beats;
      logic            exp_err;
      int              exp_len;
      int              exp_bad;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One GMII byte on the pins: low nibble/dv for the rising edge, high nibble/dv^er for the falling edge
   task automatic send_byte(input logic [7:0] b, input logic dv, input logic er, output int pin_cyc);
      rgmii_rxd    = b[3:0];
      rgmii_rx_ctl = dv;
      @(posedge clk);
      #1;
      pin_cyc      = cyc;
      rgmii_rxd    = b[7:4];
      rgmii_rx_ctl = dv ^ er;
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      beats.delete();
      pin_q.delete();
      bad_cnt   = 0;
      stray_flv = 0;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int c;
      clear_log();
      for (int i = 0; i < v.n_pre; i++) send_byte(8'h55, 1'b1, 1'b0, c);
      send_byte(v.sfd, 1'b1, 1'b0, c);
      for (int i = 0; i < v.n_pay; i++) begin
         send_byte(v.pay[i], 1'b1, (i == v.err_idx), c);
         pin_q.push_back(c);
      end
      repeat (6) send_byte(idle_byte, 1'b0, 1'b0, c);

      check($sformatf("v%0d beats", k), beats.size(), v.exp_beats);
      for (int i = 0; i < v.exp_beats && i < beats.size(); i++) begin
         check($sformatf("v%0d data[%0d]", k, i), beats[i].d, v.pay[i]);
         check($sformatf("v%0d latency[%0d]", k, i), beats[i].c - pin_q[i], 3);
         check($sformatf("v%0d last[%0d]", k, i), beats[i].last, (i == v.exp_beats - 1));
         check($sformatf("v%0d flv[%0d]", k, i), beats[i].flv, (i == v.exp_beats - 1));
         if (i == v.exp_beats - 1) begin
            check($sformatf("v%0d m_error", k), beats[i].err, v.exp_err);
            check($sformatf("v%0d frame_len", k), beats[i].len, v.exp_len);
         end
      end
      check($sformatf("v%0d bad_frame pulses", k), bad_cnt, v.exp_bad);
      check($sformatf("v%0d stray last/flv", k), stray_flv, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic [7:0] bb [6];

      vecs[0] = '{n_pre: 7, sfd: 8'hD5, n_pay: 4, pay: 64'h00000000_04030201, err_idx: -1,
                  exp_beats: 4, exp_err: 1'b0, exp_len: 4, exp_bad: 0};
      vecs[1] = '{n_pre: 1, sfd: 8'hD5, n_pay: 2, pay: 64'h00000000_0000BBAA, err_idx: -1,
                  exp_beats: 0, exp_err: 1'b0, exp_len: 0, exp_bad: 1};
      vecs[2] = '{n_pre: 3, sfd: 8'hD5, n_pay: 5, pay: 64'h00000014_13121110, err_idx: 1,
                  exp_beats: 5, exp_err: 1'b1, exp_len: 5, exp_bad: 0};
      vecs[3] = '{n_pre: 2, sfd: 8'hD5, n_pay: 1, pay: 64'h00000000_000000A5, err_idx: -1,
                  exp_beats: 1, exp_err: 1'b0, exp_len: 1, exp_bad: 0};
      vecs[4] = '{n_pre: 2, sfd: 8'hD5, n_pay: 0, pay: 64'h0, err_idx: -1,
                  exp_beats: 0, exp_err: 1'b0, exp_len: 0, exp_bad: 1};
      vecs[5] = '{n_pre: 2, sfd: 8'h5D, n_pay: 2, pay: 64'h00000000_00002211, err_idx: -1,
                  exp_beats: 0, exp_err: 1'b0, exp_len: 0, exp_bad: 1};
      vecs[6] = '{n_pre: 9, sfd: 8'hD5, n_pay: 3, pay: 64'h00000000_00C3C2C1, err_idx: 2,
                  exp_beats: 3, exp_err: 1'b1, exp_len: 3, exp_bad: 0};

      rst_n        = 1'b0;
      rgmii_rxd    = 4'h0;
      rgmii_rx_ctl = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset stream outputs",
            {m_if.m_data, m_if.m_valid, m_if.m_last, m_if.m_error, m_if.frame_len, m_if.frame_len_valid},
            '0);
      check("reset side outputs", {stat_bad_frame, link_up, speed, full_duplex}, '0);
      rst_n = 1'b1;
      repeat (2) send_byte(idle_byte, 1'b0, 1'b0, c);

      for (int k = 0; k < NV; k++) run_vec(k, vecs[k]);

      // Reset asserted during payload byte 3: the partial frame is discarded
      clear_log();
      repeat (2) send_byte(8'h55, 1'b1, 1'b0, c);
      send_byte(8'hD5, 1'b1, 1'b0, c);
      send_byte(8'h31, 1'b1, 1'b0, c);
      send_byte(8'h32, 1'b1, 1'b0, c);
      rgmii_rxd    = 4'h3;
      rgmii_rx_ctl = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid-reset stream outputs",
            {m_if.m_data, m_if.m_valid, m_if.m_last, m_if.m_error, m_if.frame_len, m_if.frame_len_valid},
            '0);
      check("mid-reset bad_frame", stat_bad_frame, 1'b0);
      rgmii_rxd = 4'h3;
      @(negedge clk);
      #1;
      send_byte(8'h34, 1'b1, 1'b0, c);
      send_byte(8'h35, 1'b1, 1'b0, c);
      repeat (2) send_byte(idle_byte, 1'b0, 1'b0, c);
      rst_n = 1'b1;
      repeat (4) send_byte(idle_byte, 1'b0, 1'b0, c);
      check("reset frame beats", beats.size(), 0);
      check("reset frame bad pulses", bad_cnt, 0);
      check("reset frame stray last", stray_flv, 0);
      run_vec(10, vecs[0]);

      // Two 3-byte frames separated by a single idle byte
      clear_log();
      bb = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
      for (int f = 0; f < 2; f++) begin
         repeat (2) send_byte(8'h55, 1'b1, 1'b0, c);
         send_byte(8'hD5, 1'b1, 1'b0, c);
         for (int i = 0; i < 3; i++) begin
            send_byte(bb[f*3+i], 1'b1, 1'b0, c);
            pin_q.push_back(c);
         end
         send_byte(idle_byte, 1'b0, 1'b0, c);
      end
      repeat (5) send_byte(idle_byte, 1'b0, 1'b0, c);
      check("b2b beats", beats.size(), 6);
      for (int i = 0; i < 6 && i < beats.size(); i++) begin
         check($sformatf("b2b data[%0d]", i), beats[i].d, bb[i]);
         check($sformatf("b2b latency[%0d]", i), beats[i].c - pin_q[i], 3);
         check($sformatf("b2b last[%0d]", i), beats[i].last, (i == 2 || i == 5));
         if (i == 2 || i == 5) begin
            check($sformatf("b2b frame_len[%0d]", i), beats[i].len, 3);
            check($sformatf("b2b flv[%0d]", i), beats[i].flv, 1'b1);
            check($sformatf("b2b m_error[%0d]", i), beats[i].err, 1'b0);
         end
      end
      check("b2b bad pulses", bad_cnt, 0);

`ifdef RGMII_RX_INBAND_STATUS_EN
      // Idle 0x0D: link up, 1000M, full duplex, visible two edges after the pin edge
      send_byte(8'h0D, 1'b0, 1'b0, c);
      rgmii_rxd    = 4'hD;
      rgmii_rx_ctl = 1'b0;
      @(posedge clk);
      #1;
      check("status one edge early", {link_up, speed, full_duplex}, 4'b0000);
      rgmii_rxd = 4'h0;
      @(negedge clk);
      #1;
      rgmii_rxd = 4'hD;
      @(posedge clk);
      #1;
      check("status link_up", link_up, 1'b1);
      check("status speed", speed, 2'b10);
      check("status full_duplex", full_duplex, 1'b1);
      rgmii_rxd = 4'h0;
      @(negedge clk);
      #1;
      idle_byte = 8'h0D;
      run_vec(20, vecs[0]);
      check("status after frame", {link_up, speed, full_duplex}, 4'b1101);
`else
      // Without the status feature the outputs stay 0 even for idle 0x0D
      repeat (4) send_byte(8'h0D, 1'b0, 1'b0, c);
      check("status disabled", {link_up, speed, full_duplex}, 4'b0000);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/rgmii_ddr_rx.md
# rgmii_ddr_rx

- Generic-target RGMII receive front end, the receive-side counterpart of the generic output DDR flip-flop used on the transmit path.
- Captures 4-bit DDR data and the DDR control line on both clock edges, then realigns them into single-rate GMII bytes.
- Detects preamble/SFD and delivers frame payload as a byte stream with last and error flags plus a length report.
- Sits between the PHY pins and the MAC receive logic, clocked by the already phase-aligned RGMII RX clock.

## Interface

- `MIN_PREAMBLE`, default 2: minimum count of 0x55 bytes required before 0xD5 for a valid frame start (range 1–7).
- `CNT_WIDTH`, default 16: width of the frame length counter.

Ports (name, direction, width, meaning):

- `clk`, in, 1: RGMII RX clock; both edges sample pins.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rgmii_rxd`, in, 4: DDR data. Rising edge carries bits[3:0]; falling edge carries bits[7:4].
- `rgmii_rx_ctl`, in, 1: DDR control. Rising edge carries rx_dv; falling edge carries rx_dv XOR rx_er.
- `m_data`, out, 8: payload byte.
- `m_valid`, out, 1: payload byte strobe. Single cycle, no backpressure.
- `m_last`, out, 1: final byte of frame; qualified by `m_valid`.
- `m_error`, out, 1: frame contained rx_er; qualified by `m_last`.
- `frame_len`, out, `CNT_WIDTH`: payload byte count (FCS included); qualified by `frame_len_valid`.
- `frame_len_valid`, out, 1: one-cycle pulse, coincident with `m_last`.
- `stat_bad_frame`, out, 1: one-cycle pulse on a discarded frame.
- `link_up`, out, 1: in-band link status.
- `speed`, out, 2: in-band speed (00 = 10M, 01 = 100M, 10 = 1000M).
- `full_duplex`, out, 1: in-band duplex.

## Operation

**Capture**
- Posedge registers rise_d/rise_c; negedge registers fall_d/fall_c.
- Next posedge assembles byte = {fall_d, rise_d}, dv = rise_c, er = rise_c ^ fall_c.

**FSM states**
- IDLE
  - dv=1, er=0, byte=0x55 → PREAMBLE with pre_cnt=1.
  - dv=1 with any other byte, or with er=1 → DROP.
  - dv=0 (including false carrier, dv=0 er=1) → stay.
- PREAMBLE
  - 0x55 → pre_cnt+1, saturating at 7.
  - 0xD5 with pre_cnt ≥ `MIN_PREAMBLE` → DATA; clear length counter and error flag.
  - 0xD5 with short preamble, any other byte, or er=1 → DROP.
  - dv=0 → IDLE and pulse `stat_bad_frame`.
- DATA
  - Each dv=1 byte enters a one-byte hold register; the previously held byte is emitted with `m_valid`=1, `m_last`=0.
  - er=1 sets a sticky error flag; the byte is still delivered.
  - dv=0 → emit held byte with `m_last`=1, `m_error`=flag, `frame_len_valid`=1; → IDLE.
  - A frame of SFD then dv=0 (zero payload): no `m_valid`; pulse `stat_bad_frame`.
- DROP
  - Wait for dv=0 → IDLE, pulse `stat_bad_frame` once.

**Arithmetic and reset**
- Length counter increments per payload byte and saturates at all-ones; `frame_len` holds its value until the next report.
- Reset values: all outputs 0, FSM IDLE, counters and hold register cleared.
- Reset mid-frame: partial frame discarded, no `m_last` emitted. Reception resumes at the first dv rise seen in IDLE after release.

## Timing

- Latency is 3 clk cycles: a byte whose low nibble is on the pins at rising edge N appears on `m_data`/`m_valid` after rising edge N+3. This holds for last bytes too.
- Back-to-back frames separated by a single dv=0 byte are both received; IDLE re-arms on the cycle after `m_last`.
- Output rate is at most one byte per cycle; gaps in `m_valid` occur only between frames.

## Configuration

- `RGMII_RX_INBAND_STATUS_EN` defined: on every assembled byte with dv=0 and er=0, register
  - `link_up` = byte[0]
  - `speed` = byte[2:1]
  - `full_duplex` = byte[3]

  Values update 2 cycles after the pin rising edge and hold during frames.
- Undefined: `link_up`, `speed` and `full_duplex` are constant 0 and no status logic is synthesized.

## Test plan

- Seven 0x55, then 0xD5, then 01 02 03 04, then dv low → four `m_valid` beats 01..04, each 3 cycles after its pin edge. `m_last` on 04, `m_error`=0, `frame_len`=4 pulsed with `m_last`.
- With `MIN_PREAMBLE`=2: 55 D5 AA BB, then dv low → no `m_valid`; exactly one `stat_bad_frame` pulse after dv falls.
- 5-byte payload with er=1 on byte 2 → all 5 bytes delivered; `m_error`=1 on `m_last`; `frame_len`=5.
- `rst_n` low during payload byte 3 → all outputs 0 immediately, no `m_last`; the following frame is received intact after release.
- Two 3-byte frames separated by one idle byte → two complete frames, each with its own `m_last` and `frame_len`=3.
- With the macro defined: idle byte 0x0D → `link_up`=1, `speed`=2'b10, `full_duplex`=1 two cycles later; values unchanged through a subsequent frame.
